// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic matrix multiplier: FSM states and result-width helper.
package systolic_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FEED = 2'd1,
    DONE = 2'd2
  } state_t;

  // Worst case |sum| is K * 2^(2N-2); one extra bit covers the sign.
  function automatic int cw_of(input int n, input int k);
    return 2 * n + $clog2(k) + 1;
  endfunction

endpackage

// File: rtl/mac_pe.sv
// Systolic processing element: registered a/b forwarding and a signed multiply-accumulate.
module mac_pe #(
  parameter int N  = 16,
  parameter int CW = 35
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          clr_acc,
  input  logic          clr_fwd,
  input  logic [N-1:0]  a_in,
  input  logic [N-1:0]  b_in,
  output logic [N-1:0]  a_out,
  output logic [N-1:0]  b_out,
  output logic [CW-1:0] sum
);

  logic [CW-1:0]        acc;
  logic signed [2*N-1:0] prod;
  logic signed [CW-1:0]  prod_ext;

  assign prod     = $signed(a_in) * $signed(b_in);
  assign prod_ext = prod;
  // sum is exposed so the top can capture the final value on the same edge it is accumulated.
  assign sum      = acc + prod_ext;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc <= '0;
    end else if (clr_acc) begin
      acc <= '0;
    end else if (en) begin
      acc <= sum;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_out <= '0;
      b_out <= '0;
    end else if (clr_fwd) begin
      a_out <= '0;
      b_out <= '0;
    end else if (en) begin
      a_out <= a_in;
      b_out <= b_in;
    end
  end

endmodule

// File: rtl/systolic_matmul.sv
// Output-stationary systolic array computing C = A*B (or C += A*B) with skewed operand feed.
module systolic_matmul
  import systolic_pkg::*;
#(
  parameter int N    = 16,
  parameter int ROWS = 4,
  parameter int COLS = 4,
  parameter int K    = 4,
  localparam int CW  = cw_of(N, K)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     in_acc,
  input  logic [ROWS*K*N-1:0]      a,
  input  logic [K*COLS*N-1:0]      b,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [ROWS*COLS*CW-1:0]  c
);

  localparam int LAT = K + ROWS + COLS - 2;
  localparam int TW  = (LAT > 1) ? $clog2(LAT) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(LAT - 1);

  state_t        state, state_next;
  logic [TW-1:0] t;
  logic          accept;
  logic          feeding;
  logic          last;
  logic          clr_acc;

  logic [N-1:0]  a_m   [ROWS][K];
  logic [N-1:0]  b_m   [K][COLS];
  logic [N-1:0]  inj_a [ROWS];
  logic [N-1:0]  inj_b [COLS];
  logic [N-1:0]  a_link [ROWS][COLS+1];
  logic [N-1:0]  b_link [ROWS+1][COLS];
  logic [CW-1:0] sum    [ROWS][COLS];
  logic [CW-1:0] c_q    [ROWS][COLS];
  logic          unused_edge;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign accept    = in_valid && in_ready;
  assign feeding   = (state == FEED);
  assign last      = feeding && (t == T_LAST);
  assign clr_acc   = accept && !in_acc;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      t     <= '0;
    end else begin
      state <= state_next;
      if (feeding && !last) begin
        t <= t + TW'(1);
      end else begin
        t <= '0;
      end
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (accept)    state_next = FEED;
      FEED:    if (last)      state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default:                state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned r = 0; r < ROWS; r++)
        for (int unsigned k = 0; k < K; k++)
          a_m[r][k] <= '0;
      for (int unsigned k = 0; k < K; k++)
        for (int unsigned j = 0; j < COLS; j++)
          b_m[k][j] <= '0;
    end else if (accept) begin
      for (int unsigned r = 0; r < ROWS; r++)
        for (int unsigned k = 0; k < K; k++)
          a_m[r][k] <= a[(r*K+k)*N +: N];
      for (int unsigned k = 0; k < K; k++)
        for (int unsigned j = 0; j < COLS; j++)
          b_m[k][j] <= b[(k*COLS+j)*N +: N];
    end
  end

  // Row r carries A[r][t-r], column j carries B[t-j][j]; zero outside the valid k range.
  always_comb begin
    for (int unsigned r = 0; r < ROWS; r++) begin
      inj_a[r] = '0;
      for (int unsigned k = 0; k < K; k++)
        if (32'(t) == r + k) inj_a[r] = a_m[r][k];
    end
    for (int unsigned j = 0; j < COLS; j++) begin
      inj_b[j] = '0;
      for (int unsigned k = 0; k < K; k++)
        if (32'(t) == j + k) inj_b[j] = b_m[k][j];
    end
  end

  for (genvar j = 0; j < COLS; j++) begin : g_top
    assign b_link[0][j] = inj_b[j];
  end

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    assign a_link[r][0] = inj_a[r];
    for (genvar j = 0; j < COLS; j++) begin : g_col
      mac_pe #(
        .N  (N),
        .CW (CW)
      ) u_pe (
        .clk     (clk),
        .rst     (rst),
        .en      (feeding),
        .clr_acc (clr_acc),
        .clr_fwd (accept),
        .a_in    (a_link[r][j]),
        .b_in    (b_link[r][j]),
        .a_out   (a_link[r][j+1]),
        .b_out   (b_link[r+1][j]),
        .sum     (sum[r][j])
      );
    end
  end

  // Result is a separate register so C stays put while the accumulators are cleared and refilled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned r = 0; r < ROWS; r++)
        for (int unsigned j = 0; j < COLS; j++)
          c_q[r][j] <= '0;
    end else if (last) begin
      for (int unsigned r = 0; r < ROWS; r++)
        for (int unsigned j = 0; j < COLS; j++)
          c_q[r][j] <= sum[r][j];
    end
  end

  always_comb begin
    c = '0;
    for (int unsigned r = 0; r < ROWS; r++)
      for (int unsigned j = 0; j < COLS; j++)
        c[(r*COLS+j)*CW +: CW] = c_q[r][j];
  end

  always_comb begin
    unused_edge = 1'b0;
    for (int unsigned r = 0; r < ROWS; r++)
      unused_edge = unused_edge ^ (^a_link[r][COLS]);
    for (int unsigned j = 0; j < COLS; j++)
      unused_edge = unused_edge ^ (^b_link[ROWS][j]);
  end

endmodule

// File: tb/tb_systolic_matmul.sv
// Bench for systolic_matmul: directed vector table, random transactions against a matrix model, and corner sequences.
module tb_systolic_matmul;
  import systolic_pkg::*;

  localparam int N    = 16;
  localparam int ROWS = 4;
  localparam int COLS = 4;
  localparam int K    = 4;
  localparam int CW   = cw_of(N, K);
  localparam int LAT  = K + ROWS + COLS - 2;
  localparam int AW   = ROWS * K * N;
  localparam int BW   = K * COLS * N;
  localparam int W    = ROWS * COLS * CW;
  localparam int NV   = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          in_acc = 1'b0;
  logic [AW-1:0] a = '0;
  logic [BW-1:0] b = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  c;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [AW-1:0] a;
    logic [BW-1:0] b;
    logic          acc;
    logic [W-1:0]  exp;
  } vec_t;

  vec_t          vecs [NV];
  int            am [ROWS][K];
  int            bm [K][COLS];
  longint        em [ROWS][COLS];
  logic [CW-1:0] model_c [ROWS][COLS];

  always #5 clk = ~clk;

  systolic_matmul #(
    .N    (N),
    .ROWS (ROWS),
    .COLS (COLS),
    .K    (K)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_acc    (in_acc),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .c         (c)
  );

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [CW-1:0] c_at(input int r, input int j);
    return c[(r*COLS+j)*CW +: CW];
  endfunction

  function automatic logic [W-1:0] pack_model();
    logic [W-1:0] v = '0;
    for (int r = 0; r < ROWS; r++)
      for (int j = 0; j < COLS; j++)
        v[(r*COLS+j)*CW +: CW] = model_c[r][j];
    return v;
  endfunction

  task automatic clear_mats();
    for (int r = 0; r < ROWS; r++) for (int k = 0; k < K; k++) am[r][k] = 0;
    for (int k = 0; k < K; k++) for (int j = 0; j < COLS; j++) bm[k][j] = 0;
    for (int r = 0; r < ROWS; r++) for (int j = 0; j < COLS; j++) em[r][j] = 0;
  endtask

  task automatic rand_mats();
    for (int r = 0; r < ROWS; r++)
      for (int k = 0; k < K; k++) am[r][k] = int'($urandom_range(0, 65535)) - 32768;
    for (int k = 0; k < K; k++)
      for (int j = 0; j < COLS; j++) bm[k][j] = int'($urandom_range(0, 65535)) - 32768;
  endtask

  task automatic pack_ops(output logic [AW-1:0] av, output logic [BW-1:0] bv);
    av = '0;
    bv = '0;
    for (int r = 0; r < ROWS; r++)
      for (int k = 0; k < K; k++) av[(r*K+k)*N +: N] = N'(am[r][k]);
    for (int k = 0; k < K; k++)
      for (int j = 0; j < COLS; j++) bv[(k*COLS+j)*N +: N] = N'(bm[k][j]);
  endtask

  task automatic save_vec(input int i, input logic acc);
    vec_t v;
    pack_ops(v.a, v.b);
    v.acc = acc;
    v.exp = '0;
    for (int r = 0; r < ROWS; r++)
      for (int j = 0; j < COLS; j++) v.exp[(r*COLS+j)*CW +: CW] = CW'(em[r][j]);
    vecs[i] = v;
  endtask

  // C = A*B or C_prev + A*B, reduced modulo 2^CW.
  task automatic model_update(input logic acc);
    for (int r = 0; r < ROWS; r++)
      for (int j = 0; j < COLS; j++) begin
        longint s = 0;
        for (int k = 0; k < K; k++) s += longint'(am[r][k]) * longint'(bm[k][j]);
        model_c[r][j] = (acc ? model_c[r][j] : CW'(0)) + CW'(s);
      end
  endtask

  task automatic check_c(input string tag);
    for (int r = 0; r < ROWS; r++)
      for (int j = 0; j < COLS; j++)
        check($sformatf("%s_c%0d_%0d", tag, r, j), W'(c_at(r, j)), W'(model_c[r][j]));
  endtask

  // Called at a negedge in IDLE; returns at the negedge where out_valid is first seen (or the bound expires).
  task automatic txn(input logic [AW-1:0] av, input logic [BW-1:0] bv, input logic acc, input string tag);
    int lat = -1;
    in_valid = 1'b1;
    in_acc   = acc;
    a        = av;
    b        = bv;
    check({tag, "_in_ready_idle"}, W'(in_ready), W'(1));
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    in_acc   = 1'b0;
    check({tag, "_in_ready_feed"}, W'(in_ready), W'(0));
    check({tag, "_c_hold_feed"}, c, pack_model());
    for (int e = 1; e <= LAT + 4; e++) begin
      @(negedge clk);
      if (out_valid) begin
        lat = e;
        break;
      end
    end
    check({tag, "_latency"}, W'(lat), W'(LAT));
  endtask

  task automatic release_out(input string tag);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_out_valid_drop"}, W'(out_valid), W'(0));
    check({tag, "_in_ready_back"}, W'(in_ready), W'(1));
  endtask

  initial begin
    logic [AW-1:0] av, av2;
    logic [BW-1:0] bv;
    int            rises;

    // Directed vector table.
    clear_mats();
    for (int r = 0; r < ROWS; r++) am[r][r] = 1;
    for (int k = 0; k < K; k++)
      for (int j = 0; j < COLS; j++) begin
        bm[k][j] = k * COLS + j + 1;
        em[k][j] = k * COLS + j + 1;
      end
    save_vec(0, 1'b0);

    clear_mats();
    am[0][0] = 1; am[0][1] = 2; am[1][0] = 3; am[1][1] = 4;
    bm[0][0] = 1; bm[0][1] = 2; bm[1][0] = 3; bm[1][1] = 4;
    em[0][0] = 7; em[0][1] = 10; em[1][0] = 15; em[1][1] = 22;
    save_vec(1, 1'b0);
    em[0][0] = 14; em[0][1] = 20; em[1][0] = 30; em[1][1] = 44;
    save_vec(2, 1'b1);

    clear_mats();
    for (int r = 0; r < ROWS; r++) for (int k = 0; k < K; k++) am[r][k] = -32768;
    for (int k = 0; k < K; k++) for (int j = 0; j < COLS; j++) bm[k][j] = -32768;
    for (int r = 0; r < ROWS; r++) for (int j = 0; j < COLS; j++) em[r][j] = 64'sd4294967296;
    save_vec(3, 1'b0);
    for (int r = 0; r < ROWS; r++) for (int j = 0; j < COLS; j++) em[r][j] = 64'sd8589934592;
    save_vec(4, 1'b1);
    for (int r = 0; r < ROWS; r++) for (int j = 0; j < COLS; j++) em[r][j] = 64'sd12884901888;
    save_vec(5, 1'b1);
    // 4 * 2^32 = 2^34 exceeds the signed 35-bit range and wraps to -2^34.
    for (int r = 0; r < ROWS; r++) for (int j = 0; j < COLS; j++) em[r][j] = -64'sd17179869184;
    save_vec(6, 1'b1);

    clear_mats();
    am[0][0] = -1; am[0][1] = 2;  am[0][2] = -3;
    bm[0][0] = 4;  bm[1][0] = -5; bm[2][0] = 6;
    em[0][0] = -32;
    save_vec(7, 1'b0);

    for (int r = 0; r < ROWS; r++) for (int j = 0; j < COLS; j++) model_c[r][j] = '0;

    // Reset state, then first accept on the first edge after release.
    @(negedge clk);
    @(negedge clk);
    check("rst_out_valid", W'(out_valid), W'(0));
    check("rst_c", c, '0);
    rst = 1'b1;
    check("rst_in_ready", W'(in_ready), W'(1));

    for (int i = 0; i < NV; i++) begin
      txn(vecs[i].a, vecs[i].b, vecs[i].acc, $sformatf("vec%0d", i));
      for (int r = 0; r < ROWS; r++)
        for (int j = 0; j < COLS; j++) begin
          check($sformatf("vec%0d_c%0d_%0d", i, r, j), W'(c_at(r, j)),
                W'(vecs[i].exp[(r*COLS+j)*CW +: CW]));
          model_c[r][j] = vecs[i].exp[(r*COLS+j)*CW +: CW];
        end
      release_out($sformatf("vec%0d", i));
    end

    // Randomized transactions against the matrix model, with random consumer back-pressure.
    for (int i = 0; i < 12; i++) begin
      logic acc;
      int   hold;
      acc = (i == 0) ? 1'b0 : 1'($urandom_range(0, 1));
      rand_mats();
      pack_ops(av, bv);
      txn(av, bv, acc, $sformatf("rnd%0d", i));
      model_update(acc);
      check_c($sformatf("rnd%0d", i));
      hold = int'($urandom_range(0, 2));
      for (int h = 0; h < hold; h++) begin
        @(negedge clk);
        check($sformatf("rnd%0d_hold_valid", i), W'(out_valid), W'(1));
      end
      release_out($sformatf("rnd%0d", i));
    end

    // Consumer stall: output frozen, new operands ignored, single-edge release.
    rand_mats();
    pack_ops(av, bv);
    txn(av, bv, 1'b0, "stall");
    model_update(1'b0);
    rand_mats();
    pack_ops(av2, bv);
    for (int s = 0; s < 5; s++) begin
      in_valid = 1'b1;
      a        = av2;
      b        = bv;
      @(negedge clk);
      check($sformatf("stall%0d_out_valid", s), W'(out_valid), W'(1));
      check($sformatf("stall%0d_in_ready", s), W'(in_ready), W'(0));
      check($sformatf("stall%0d_c", s), c, pack_model());
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("stall_release_out_valid", W'(out_valid), W'(0));
    check("stall_release_in_ready", W'(in_ready), W'(1));
    check("stall_release_c_idle", c, pack_model());
    in_valid = 1'b0;

    // Reset pulse at FEED t=2 abandons the operation and zeroes everything.
    rand_mats();
    pack_ops(av, bv);
    @(negedge clk);
    in_valid = 1'b1;
    in_acc   = 1'b1;
    a        = av;
    b        = bv;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    in_acc   = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #2;
    check("midrst_out_valid", W'(out_valid), W'(0));
    check("midrst_c", c, '0);
    #1;
    rst = 1'b1;
    for (int r = 0; r < ROWS; r++) for (int j = 0; j < COLS; j++) model_c[r][j] = '0;
    rises = 0;
    for (int e = 0; e < LAT + 3; e++) begin
      @(negedge clk);
      if (out_valid) rises++;
    end
    check("midrst_no_out_valid", W'(rises), W'(0));
    check("midrst_in_ready", W'(in_ready), W'(1));
    check("midrst_c_after", c, '0);
    rand_mats();
    pack_ops(av, bv);
    txn(av, bv, 1'b1, "postrst");
    model_update(1'b1);
    check_c("postrst");
    release_out("postrst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/systolic_matmul.md
SYSTOLIC_MATMUL -- requirements
Module: systolic_matmul

Interface
REQ-001 Parameter N, default 16: operand width in bits, signed two's complement.
REQ-002 Parameter ROWS, default 4: rows of A and C; PE grid height.
REQ-003 Parameter COLS, default 4: columns of B and C; PE grid width.
REQ-004 Parameter K, default 4: inner dimension (A columns = B rows); K >= 1.
REQ-005 Derived constant CW = 2*N + clog2(K) + 1: result width, guaranteed overflow-free.
REQ-006 clk  input  1  sole clock; all state updates on the rising edge.
REQ-007 rst  input  1  asynchronous, active-low reset.
REQ-008 in_valid  input  1  A/B operand set offered.
REQ-009 in_ready  output  1  block can accept an operand set.
REQ-010 in_acc  input  1  sampled with the operand set: 1 = add the product into the existing C; 0 = overwrite C.
REQ-011 a  input  ROWS*K*N  matrix A, packed [ROWS][K][N].
REQ-012 b  input  K*COLS*N  matrix B, packed [K][COLS][N].
REQ-013 out_valid  output  1  C is complete and stable.
REQ-014 out_ready  input  1  consumer accepts C.
REQ-015 c  output  ROWS*COLS*CW  result, packed [ROWS][COLS][CW], signed.

Function
REQ-016 An FSM SHALL have the states IDLE, FEED and DONE.
REQ-017 in_ready SHALL be 1 only in IDLE; the handshake in_valid&&in_ready SHALL latch a, b and in_acc internally and move the FSM to FEED.
REQ-018 On accept with in_acc=0, all PE accumulators SHALL be cleared on the same edge; with in_acc=1 they SHALL be retained.
REQ-019 In FEED, a counter t runs from 0 to LAT-1, where LAT = K+ROWS+COLS-2; on cycle t, row r SHALL inject A[r][t-r] and column j SHALL inject B[t-j][j], or 0 when the index is outside 0..K-1 (skewed feed).
REQ-020 Each PE SHALL forward a to the right and b downward through one register per hop, and SHALL accumulate a*b signed into CW bits each FEED cycle.
REQ-021 When t = LAT-1 the FSM SHALL move to DONE; out_valid SHALL rise exactly LAT rising edges after the accepting edge.
REQ-022 In DONE, c SHALL equal the accumulator array and SHALL be held stable while out_valid=1 and out_ready=0.
REQ-023 The edge at which out_valid&&out_ready holds SHALL return the FSM to IDLE; out_ready asserted in the cycle that out_valid first rises SHALL complete in that cycle.
REQ-024 c SHALL keep its last value in IDLE and FEED; only out_valid qualifies it.
REQ-025 in_valid and out_ready outside IDLE/DONE respectively SHALL be ignored; a new operand set SHALL never be accepted in the same cycle as an output handshake.
REQ-026 Arithmetic SHALL be exact signed; with in_acc chains the accumulator SHALL wrap modulo 2^CW and not saturate.

Reset
REQ-027 rst low SHALL immediately force the FSM to IDLE, t=0, all accumulators, forwarding registers and latched operands to 0, and set in_ready=1 (after release), out_valid=0, c=0.
REQ-028 Reset asserted mid-FEED or mid-DONE SHALL abandon the operation with no output handshake.
REQ-029 The first accept is allowed on the first rising edge after rst deasserts.

Structure
REQ-030 A shared package systolic_pkg SHALL hold the FSM state enum and a function computing CW from N and K.
REQ-031 The PE SHALL be a sub-module mac_pe (registered a/b forwarding, signed MAC, clear and hold controls), instantiated ROWS*COLS times by generate loops.
REQ-032 Skew injection SHALL be driven by the central counter t and SHALL NOT use per-row shift-register enable chains.

Verification
REQ-033 ROWS=COLS=K=3, A=identity, B=[1..9] row-major, in_acc=0 -> out_valid after exactly 7 edges, c=B.
REQ-034 A=B=[[1,2],[3,4]] (ROWS=COLS=K=2), in_acc=0 then the same operands with in_acc=1 -> c=[[7,10],[15,22]], then [[14,20],[30,44]].
REQ-035 N=16, K=4, all A=-32768, all B=-32768 -> every c entry = 4*2^30 = 4294967296, no overflow in CW=35.
REQ-036 Mixed signs: A row [-1,2,-3], B column [4,-5,6] -> c entry = -32.
REQ-037 out_ready held low for 5 cycles after out_valid -> c and out_valid stable, in_ready=0, in_valid ignored; the release completes in one edge.
REQ-038 rst pulsed low at FEED t=2 -> out_valid never rises, c=0; the next transaction computes correctly with in_acc=1 treated against zeroed accumulators.
